// File: rtl/sdc_bram_arbiter_pkg.sv
// Shared types and constants for the SD host controller register-BRAM arbiter.
//   SDC_ADDR_W / SDC_DATA_W : BRAM word-address and data widths
//   SDC_NREQ                : number of requesters sharing the port
//   sdc_bram_req_t          : one request as presented by a requester
//   arb_state_e             : arbiter lock state
package sdc_pkg;
  localparam int SDC_ADDR_W = 8;
  localparam int SDC_DATA_W = 32;
  localparam int SDC_NREQ   = 2;

  typedef struct packed {
    logic [3:0]            we;
    logic [SDC_ADDR_W-1:0] addr;
    logic [SDC_DATA_W-1:0] wdata;
    logic                  lock;
  } sdc_bram_req_t;

  typedef enum logic {
    ARB_OPEN,
    ARB_LOCKED
  } arb_state_e;
endpackage

// File: rtl/sdc_bram_arbiter_if.sv
// Requester-side BRAM access channel.
//   valid/ready : request handshake (transfer when both high at clk edge)
//   we/addr/wdata/lock : request payload, held stable until ready
//   rvalid/rdata : one-cycle response pulse, no backpressure
// Modports: master = requester, slave = arbiter.
interface sdc_req_if;
  import sdc_pkg::*;
  logic                  valid;
  logic                  ready;
  logic [3:0]            we;
  logic [SDC_ADDR_W-1:0] addr;
  logic [SDC_DATA_W-1:0] wdata;
  logic                  lock;
  logic                  rvalid;
  logic [SDC_DATA_W-1:0] rdata;

  modport master (output valid, we, addr, wdata, lock,
                  input  ready, rvalid, rdata);
  modport slave  (input  valid, we, addr, wdata, lock,
                  output ready, rvalid, rdata);
endinterface

// File: rtl/sdc_bram_arbiter_arb.sv
// 2-way round-robin grant with lock ownership and lock timeout.
//   clk, rstn   : clock, synchronous active-low reset
//   i_valid     : per-requester request valid
//   i_lock      : per-requester lock bit of the pending request
//   o_gnt       : combinational one-hot (or zero) grant
//   o_timeout   : one-cycle pulse in the cycle a stale lock is released
module sdc_rr_arb
  import sdc_pkg::*;
#(
  parameter int LockTimeout = 1024
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [SDC_NREQ-1:0] i_valid,
  input  logic [SDC_NREQ-1:0] i_lock,
  output logic [SDC_NREQ-1:0] o_gnt,
  output logic                o_timeout
);
  localparam int            CntW   = (LockTimeout > 0) ? $clog2(LockTimeout + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(LockTimeout);

  arb_state_e          r_state, w_state_nxt;
  logic                r_owner, w_owner_nxt;
  logic                r_last, w_last_nxt;    // requester served most recently
  logic [CntW-1:0]     r_cnt, w_cnt_nxt;      // cycles locked without owner acceptance
  logic [SDC_NREQ-1:0] w_gnt;
  logic                w_acc, w_sel, w_timeout;

  // Grants are gated by rstn so nothing is accepted while reset is applied.
  always_comb begin
    w_gnt = '0;
    if (rstn) begin
      if (r_state == ARB_LOCKED)  w_gnt[r_owner] = i_valid[r_owner];
      else if (&i_valid)          w_gnt[~r_last] = 1'b1;
      else                        w_gnt = i_valid;
    end
  end

  assign w_acc = |w_gnt;
  assign w_sel = w_gnt[1];
  // An owner acceptance in the expiry cycle wins over the timeout.
  assign w_timeout = (LockTimeout != 0) && rstn && (r_state == ARB_LOCKED) &&
                     (r_cnt == CntMax) && !w_acc;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    if (w_acc) begin
      w_last_nxt  = w_sel;
      w_owner_nxt = w_sel;
      w_cnt_nxt   = '0;
      // Locked acceptances are always from the owner, so lock=0 releases.
      w_state_nxt = i_lock[w_sel] ? ARB_LOCKED : ARB_OPEN;
    end else if (w_timeout) begin
      w_state_nxt = ARB_OPEN;
      w_cnt_nxt   = '0;
      w_last_nxt  = r_owner;  // non-owner gets priority next
    end else if (r_state == ARB_LOCKED && LockTimeout != 0) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state <= ARB_OPEN;
      r_owner <= 1'b0;
      r_last  <= 1'b1;  // requester 0 has priority out of reset
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_gnt     = w_gnt;
  assign o_timeout = w_timeout;
endmodule

// File: rtl/sdc_bram_arbiter.sv
// Shares the SD controller's single register-BRAM port (read latency 1)
// between the CPU bridge (m0) and the boot/DMA sequencer (m1).
//   clk, rstn       : clock, synchronous active-low reset
//   m0, m1          : requester channels (sdc_req_if.slave)
//   bram_en/we/addr/wrdata : registered BRAM command, cycle T+1 for accept at T
//   bram_rddata     : BRAM read data, valid the cycle after bram_en
//   lock_timeout    : pulse when a held lock is force-released
module sdc_bram_arbiter
  import sdc_pkg::*;
#(
  parameter int LockTimeout = 1024,
  parameter int AddrWidth   = SDC_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rstn,
  sdc_req_if.slave              m0,
  sdc_req_if.slave              m1,
  output logic                  bram_en,
  output logic [3:0]            bram_we,
  output logic [AddrWidth-1:0]  bram_addr,
  output logic [SDC_DATA_W-1:0] bram_wrdata,
  input  logic [SDC_DATA_W-1:0] bram_rddata,
  output logic                  lock_timeout
);
  sdc_bram_req_t         w_req [SDC_NREQ];
  logic [SDC_NREQ-1:0]   w_gnt;
  logic                  w_acc;
  logic [3:0]            w_iss_we;
  logic [SDC_ADDR_W-1:0] w_iss_addr;
  logic [SDC_DATA_W-1:0] w_iss_wdata;

  // r_vld_pipe[0]: issue stage (BRAM access), [1]: response stage
  logic [1:0]            r_vld_pipe;
  logic                  r_s1_id, r_s2_id, r_s2_rd;
  logic [3:0]            r_we;
  logic [SDC_ADDR_W-1:0] r_addr;
  logic [SDC_DATA_W-1:0] r_wdata;

  assign w_req[0] = '{we: m0.we, addr: m0.addr, wdata: m0.wdata, lock: m0.lock};
  assign w_req[1] = '{we: m1.we, addr: m1.addr, wdata: m1.wdata, lock: m1.lock};

  sdc_rr_arb #(.LockTimeout(LockTimeout)) u_arb (
    .clk       (clk),
    .rstn      (rstn),
    .i_valid   ({m1.valid, m0.valid}),
    .i_lock    ({w_req[1].lock, w_req[0].lock}),
    .o_gnt     (w_gnt),
    .o_timeout (lock_timeout)
  );

  assign m0.ready    = w_gnt[0];
  assign m1.ready    = w_gnt[1];
  assign w_acc       = |w_gnt;
  assign w_iss_we    = w_gnt[1] ? w_req[1].we    : w_req[0].we;
  assign w_iss_addr  = w_gnt[1] ? w_req[1].addr  : w_req[0].addr;
  assign w_iss_wdata = w_gnt[1] ? w_req[1].wdata : w_req[0].wdata;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_vld_pipe <= '0;
      r_s1_id    <= 1'b0;
      r_s2_id    <= 1'b0;
      r_s2_rd    <= 1'b0;
      r_we       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[0], w_acc};
      r_s1_id    <= w_gnt[1];
      r_s2_id    <= r_s1_id;
      r_s2_rd    <= (r_we == 4'h0);
      // Idle cycles drive a zero command so the bus is quiet when bram_en=0.
      r_we       <= w_acc ? w_iss_we    : '0;
      r_addr     <= w_acc ? w_iss_addr  : '0;
      r_wdata    <= w_acc ? w_iss_wdata : '0;
    end
  end

  assign bram_en     = r_vld_pipe[0];
  assign bram_we     = r_we;
  assign bram_addr   = r_addr;
  assign bram_wrdata = r_wdata;

  assign m0.rvalid = r_vld_pipe[1] & ~r_s2_id;
  assign m1.rvalid = r_vld_pipe[1] &  r_s2_id;
  assign m0.rdata  = (m0.rvalid && r_s2_rd) ? bram_rddata : '0;
  assign m1.rdata  = (m1.rvalid && r_s2_rd) ? bram_rddata : '0;
endmodule

// File: tb/tb_sdc_bram_arbiter.sv
// Self-checking bench for sdc_bram_arbiter: behavioural model compared every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_sdc_bram_arbiter;
  import sdc_pkg::*;
  localparam int LT = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  sdc_req_if m0_if ();
  sdc_req_if m1_if ();

  logic        bram_en, lock_timeout;
  logic [3:0]  bram_we;
  logic [7:0]  bram_addr;
  logic [31:0] bram_wrdata;
  logic [31:0] bram_rddata = '0;

  logic        d_valid [2];
  logic [3:0]  d_we    [2];
  logic [7:0]  d_addr  [2];
  logic [31:0] d_wd    [2];
  logic        d_lock  [2];

  assign m0_if.valid = d_valid[0];
  assign m0_if.we    = d_we[0];
  assign m0_if.addr  = d_addr[0];
  assign m0_if.wdata = d_wd[0];
  assign m0_if.lock  = d_lock[0];
  assign m1_if.valid = d_valid[1];
  assign m1_if.we    = d_we[1];
  assign m1_if.addr  = d_addr[1];
  assign m1_if.wdata = d_wd[1];
  assign m1_if.lock  = d_lock[1];

  sdc_bram_arbiter #(.LockTimeout(LT), .AddrWidth(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .m0           (m0_if),
    .m1           (m1_if),
    .bram_en      (bram_en),
    .bram_we      (bram_we),
    .bram_addr    (bram_addr),
    .bram_wrdata  (bram_wrdata),
    .bram_rddata  (bram_rddata),
    .lock_timeout (lock_timeout)
  );

  // BRAM: read-first, latency 1, byte write enables.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (bram_en) begin
      bram_rddata <= mem[bram_addr];
      for (int b = 0; b < 4; b++)
        if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wrdata[8*b +: 8];
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          started  = 0;
  bit          m_locked = 0;
  int          m_owner  = 0;
  int          m_last   = 1;
  int          m_idle   = 0;
  bit          s1_v = 0;
  int          s1_p = 0;
  logic [3:0]  s1_we = '0;
  logic [7:0]  s1_a  = '0;
  logic [31:0] s1_wd = '0;
  bit          s2_v = 0;
  int          s2_p = 0;
  logic [31:0] s2_d = '0;

  always @(negedge clk) begin
    logic [1:0]  v, exp_rdy;
    bit          exp_to;
    int          p;
    logic [31:0] cap;
    v       = {d_valid[1], d_valid[0]};
    exp_rdy = 2'b00;
    exp_to  = 0;
    if (rstn) begin
      if (m_locked) begin
        exp_rdy[m_owner] = v[m_owner];
        exp_to = (m_idle == LT) && !v[m_owner];
      end else if (v == 2'b11) begin
        exp_rdy[1 - m_last] = 1'b1;
      end else begin
        exp_rdy = v;
      end
    end
    if (started) begin
      chk("ready", {m1_if.ready, m0_if.ready}, exp_rdy);
      chk("lock_timeout", lock_timeout, exp_to);
      chk("bram_bus", {bram_en, bram_we, bram_addr, bram_wrdata},
          s1_v ? {1'b1, s1_we, s1_a, s1_wd} : 45'h0);
      chk("m0_resp", {m0_if.rvalid, m0_if.rdata}, (s2_v && s2_p == 0) ? {1'b1, s2_d} : 33'h0);
      chk("m1_resp", {m1_if.rvalid, m1_if.rdata}, (s2_v && s2_p == 1) ? {1'b1, s2_d} : 33'h0);
    end
    cap = (s1_we == 4'h0) ? mem[s1_a] : 32'h0;
    if (!rstn) begin
      started  = 1;
      m_locked = 0;
      m_last   = 1;
      m_idle   = 0;
      s1_v     = 0;
      s2_v     = 0;
    end else begin
      s2_v = s1_v;
      s2_p = s1_p;
      s2_d = cap;
      s1_v = |exp_rdy;
      if (s1_v) begin
        p      = exp_rdy[1] ? 1 : 0;
        s1_p   = p;
        s1_we  = d_we[p];
        s1_a   = d_addr[p];
        s1_wd  = d_wd[p];
        m_last = p;
        m_idle = 0;
        m_locked = d_lock[p];
        if (d_lock[p]) m_owner = p;
      end else if (exp_to) begin
        m_locked = 0;
        m_idle   = 0;
        m_last   = m_owner;
      end else if (m_locked) begin
        m_idle++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    repeat (3) step();
    rstn = 1'b1;
  endtask

  // Present a request on port p and hold it until accepted; returns #1 after
  // the accepting edge.
  task automatic drive(input int p, input logic [3:0] we, input logic [7:0] a,
                       input logic [31:0] wd, input logic lk);
    int n = 0;
    d_valid[p] = 1'b1; d_we[p] = we; d_addr[p] = a; d_wd[p] = wd; d_lock[p] = lk;
    forever begin
      @(negedge clk);
      if (p == 0 ? m0_if.ready : m1_if.ready) break;
      n++;
      if (n > 100) begin
        checks++; errors++;
        $display("FAIL handshake_timeout: port %0d no ready after %0d cycles, expected ready", p, n);
        break;
      end
    end
    @(posedge clk);
    #1;
    d_valid[p] = 1'b0; d_we[p] = '0; d_addr[p] = '0; d_wd[p] = '0; d_lock[p] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 2; i++) begin
      d_valid[i] = 0; d_we[i] = 0; d_addr[i] = 0; d_wd[i] = 0; d_lock[i] = 0;
    end
    for (int i = 0; i < 256; i++) mem[i] = {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'hC3};
    mem[8'h04] = 32'hDEAD_BEEF;

    // Reset state
    rstn = 1'b0;
    repeat (3) step();
    @(negedge clk);
    chk("reset_bram", {bram_en, bram_we, bram_addr, bram_wrdata}, 45'h0);
    chk("reset_ctl", {m0_if.ready, m1_if.ready, m0_if.rvalid, m1_if.rvalid, lock_timeout}, 5'h0);
    chk("reset_rdata", {m0_if.rdata, m1_if.rdata}, 64'h0);
    step();
    rstn = 1'b1;

    // Single read
    drive(0, 4'h0, 8'h04, 32'h0, 1'b0);
    @(negedge clk);
    chk("t1_bram_en", bram_en, 1'b1);
    chk("t1_bram_addr", bram_addr, 8'h04);
    chk("t1_bram_we", bram_we, 4'h0);
    @(negedge clk);
    chk("t1_m0_rvalid", m0_if.rvalid, 1'b1);
    chk("t1_m0_rdata", m0_if.rdata, 32'hDEADBEEF);
    chk("t1_m1_rvalid", m1_if.rvalid, 1'b0);
    step();

    // Simultaneous valid from reset: grants alternate 0,1,0,1,...
    do_reset();
    begin
      int cnt [2];
      cnt[0] = 0; cnt[1] = 0;
      d_valid[0] = 1; d_addr[0] = 8'h10;
      d_valid[1] = 1; d_addr[1] = 8'h20;
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        chk("t2_alt_grant", {m1_if.ready, m0_if.ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
        if (i > 0) chk("t2_bram_en", bram_en, 1'b1);
        step();
        cnt[i % 2]++;
        d_addr[i % 2] = d_addr[i % 2] + 8'h1;
        if (cnt[i % 2] == 4) d_valid[i % 2] = 0;
      end
      repeat (3) step();
    end

    // Lock RMW
    do_reset();
    d_valid[1] = 1; d_addr[1] = 8'h20; d_we[1] = 4'h0;
    drive(0, 4'h0, 8'h0C, 32'h0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("t3_m1_blocked", m1_if.ready, 1'b0);
      step();
    end
    drive(0, 4'hF, 8'h0C, 32'h1234_5678, 1'b0);
    @(negedge clk);
    chk("t3_m1_grant", m1_if.ready, 1'b1);
    chk("t3_wr_bram", {bram_en, bram_we, bram_addr}, {1'b1, 4'hF, 8'h0C});
    step();
    d_valid[1] = 0;
    @(negedge clk);
    chk("t3_wr_rvalid", m0_if.rvalid, 1'b1);
    chk("t3_wr_rdata", m0_if.rdata, 32'h0);
    repeat (3) step();

    // Lock timeout
    do_reset();
    d_valid[1] = 1; d_addr[1] = 8'h30;
    drive(0, 4'h0, 8'h10, 32'h0, 1'b1);
    for (int k = 1; k <= 18; k++) begin
      @(negedge clk);
      chk("t4_timeout", lock_timeout, k == 17);
      chk("t4_m1_ready", m1_if.ready, k == 18);
      if (k < 18) step();
    end
    step();
    d_valid[1] = 0;
    repeat (3) step();

    // Reset mid-operation
    drive(0, 4'h0, 8'h40, 32'h0, 1'b0);
    rstn = 1'b0;
    step();
    @(negedge clk);
    chk("t5_rvalid", {m0_if.rvalid, m1_if.rvalid}, 2'b00);
    chk("t5_bram", {bram_en, bram_we, bram_addr, bram_wrdata}, 45'h0);
    chk("t5_ctl", {m0_if.ready, m1_if.ready, lock_timeout}, 3'b000);
    step();
    rstn = 1'b1;
    d_valid[0] = 1; d_addr[0] = 8'h50;
    d_valid[1] = 1; d_addr[1] = 8'h60;
    @(negedge clk);
    chk("t5_prio", {m1_if.ready, m0_if.ready}, 2'b01);
    step();
    d_valid[0] = 0;
    @(negedge clk);
    step();
    d_valid[1] = 0;
    repeat (3) step();

    // Random traffic, checked by the model every cycle
    fork
      begin
        for (int j = 0; j < 60; j++) begin
          int idle;
          idle = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
          repeat (idle) step();
          drive(0, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                8'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) == 0);
        end
      end
      begin
        for (int j = 0; j < 60; j++) begin
          int idle;
          idle = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
          repeat (idle) step();
          drive(1, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15)),
                8'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3) == 0);
        end
      end
    join
    repeat (25) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
